// File: rtl/touch_region_sequencer.sv
// rtl/touch_region_sequencer.sv - touch qualify/commit sequencer and eight-region colour lookup
// Optional auto-repeat while held: define TOUCH_REGION_AUTOREPEAT_EN
module touch_region_sequencer #(
    parameter int HOLD_SAMPLES  = 4,
    parameter int REPEAT_FRAMES = 30
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Touch_en,
    input  logic        Coord_en,
    input  logic [11:0] X_coord,
    input  logic [11:0] Y_coord,
    input  logic        Frame_start,
    input  logic [9:0]  Pixel_X,
    input  logic [9:0]  Pixel_Y,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue,
    output logic [2:0]  Region,
    output logic        Commit,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_COMMIT = 2'd2,
        S_HELD   = 2'd3
    } state_t;

    localparam int CW = $clog2(HOLD_SAMPLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_SAMPLES - 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(HOLD_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    state_t          state_q, state_d;
    logic [2:0]      cand_q, cand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_commit;
    logic [2:0]      tbl_q [8];
    logic [2:0]      region_q;
    logic            commit_q;
    logic [7:0]      red_q, green_q, blue_q;

    logic [2:0]      touch_region;
    logic            pix_row;
    logic [1:0]      pix_col;
    logic [2:0]      pix_entry;

    assign touch_region = {Y_coord[11], X_coord[11:10]};

`ifdef TOUCH_REGION_AUTOREPEAT_EN
    localparam int FW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [FW-1:0] REPEAT_LAST = FW'(REPEAT_FRAMES - 1);
    localparam logic [FW-1:0] REPEAT_MAX  = FW'(REPEAT_FRAMES);
    logic [FW-1:0]   fcnt_q, fcnt_d;

    // Frame counter for held-press repeats
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) fcnt_q <= '0;
        else         fcnt_q <= fcnt_d;
    end

    wire unused_ok = &{1'b0, X_coord[9:0], Y_coord[10:0]};
`else
    wire unused_ok = &{1'b0, X_coord[9:0], Y_coord[10:0], Frame_start, (REPEAT_FRAMES > 0)};
`endif

    // Next-state logic: qualify samples, one commit per press, release wins
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        do_commit = 1'b0;
`ifdef TOUCH_REGION_AUTOREPEAT_EN
        fcnt_d    = fcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Touch_en && Coord_en) begin
                    cand_d  = touch_region;
                    cnt_d   = CNT_ONE;
                    state_d = (HOLD_SAMPLES == 1) ? S_COMMIT : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!Touch_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (Coord_en) begin
                    if (touch_region == cand_q) begin
                        if (cnt_q >= HOLD_LAST) begin
                            cnt_d   = HOLD_MAX;
                            state_d = S_COMMIT;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cand_d = touch_region;
                        cnt_d  = CNT_ONE;
                    end
                end
            end
            S_COMMIT: begin
                do_commit = 1'b1;
                state_d   = S_HELD;
`ifdef TOUCH_REGION_AUTOREPEAT_EN
                fcnt_d    = '0;
`endif
            end
            S_HELD: begin
                if (!Touch_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
`ifdef TOUCH_REGION_AUTOREPEAT_EN
                else if (Coord_en && (touch_region != region_q)) begin
                    cand_d  = touch_region;
                    cnt_d   = CNT_ONE;
                    fcnt_d  = '0;
                    state_d = S_SETTLE;
                end else begin
                    if (Coord_en) cand_d = touch_region;
                    if (Frame_start) begin
                        if (fcnt_q >= REPEAT_LAST) begin
                            if (cand_d == region_q) begin
                                fcnt_d  = '0;
                                state_d = S_COMMIT;
                            end else begin
                                fcnt_d = REPEAT_MAX;
                            end
                        end else begin
                            fcnt_d = fcnt_q + FW'(1);
                        end
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, candidate and settle-count registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Colour table step, Region and Commit pulse on leaving COMMIT
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < 8; i++) tbl_q[i] <= 3'(i);
            region_q <= '0;
            commit_q <= 1'b0;
        end else begin
            commit_q <= do_commit;
            if (do_commit) begin
                tbl_q[cand_q] <= tbl_q[cand_q] + 3'd1;
                region_q      <= cand_q;
            end
        end
    end

    // Pixel position to region; X beyond the panel falls into the last column
    always_comb begin
        pix_row = (Pixel_Y >= 10'd240);
        if (Pixel_X < 10'd200)      pix_col = 2'd0;
        else if (Pixel_X < 10'd400) pix_col = 2'd1;
        else if (Pixel_X < 10'd600) pix_col = 2'd2;
        else                        pix_col = 2'd3;
        pix_entry = tbl_q[{pix_row, pix_col}];
    end

    // Registered pixel colour; reads the table before any same-cycle commit
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            red_q   <= {8{pix_entry[0]}};
            blue_q  <= {8{pix_entry[1]}};
            green_q <= {8{pix_entry[2]}};
        end
    end

    assign Red    = red_q;
    assign Green  = green_q;
    assign Blue   = blue_q;
    assign Region = region_q;
    assign Commit = commit_q;
    assign State  = state_q;

endmodule

// File: tb/tb_touch_region_sequencer.sv
// tb/tb_touch_region_sequencer.sv - scoreboard bench for touch_region_sequencer
module tb_touch_region_sequencer;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Touch_en = 1'b0;
    logic        Coord_en = 1'b0;
    logic [11:0] X_coord = '0;
    logic [11:0] Y_coord = '0;
    logic        Frame_start = 1'b0;
    logic [9:0]  Pixel_X = '0;
    logic [9:0]  Pixel_Y = '0;
    logic [7:0]  Red, Green, Blue;
    logic [2:0]  Region;
    logic        Commit;
    logic [1:0]  State;

    touch_region_sequencer #(.HOLD_SAMPLES(4), .REPEAT_FRAMES(2)) dut (
        .Clock(Clock), .Resetn(Resetn), .Touch_en(Touch_en), .Coord_en(Coord_en),
        .X_coord(X_coord), .Y_coord(Y_coord), .Frame_start(Frame_start),
        .Pixel_X(Pixel_X), .Pixel_Y(Pixel_Y), .Red(Red), .Green(Green), .Blue(Blue),
        .Region(Region), .Commit(Commit), .State(State)
    );

    always #10 Clock = ~Clock;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_commits = 0;
    int          exp_commits = 0;
    logic [2:0]  exp_region_q [$];
    logic [23:0] exp_pix_q [$];
    logic [2:0]  model [8];
    logic        pix_req = 1'b0;
    logic        pix_d = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {Red, Green, Blue} for a table entry: bit0 Red, bit1 Blue, bit2 Green
    function automatic logic [23:0] rgb_of(input logic [2:0] e);
        return {{8{e[0]}}, {8{e[2]}}, {8{e[1]}}};
    endfunction

    // Commit monitor
    always @(negedge Clock) begin
        if (Resetn && Commit) begin
            n_commits++;
            if (exp_region_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: got region %0d expected no commit", Region);
            end else begin
                check("commit_region", {29'b0, Region}, {29'b0, exp_region_q.pop_front()});
            end
        end
    end

    // Pixel monitor: colour appears one cycle after the lookup was presented
    always @(posedge Clock) pix_d <= pix_req;
    always @(negedge Clock) begin
        if (pix_d) begin
            if (exp_pix_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pixel_unexpected: got %h expected no lookup", {Red, Green, Blue});
            end else begin
                check("pixel_rgb", {8'b0, Red, Green, Blue}, {8'b0, exp_pix_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_commit(input logic [2:0] r);
        exp_region_q.push_back(r);
        exp_commits++;
        model[r] = model[r] + 3'd1;
    endtask

    task automatic set_coord(input logic [2:0] r);
        X_coord = {r[1:0], 10'h0};
        Y_coord = r[2] ? 12'h800 : 12'h000;
    endtask

    task automatic sample(input logic [2:0] r);
        set_coord(r);
        Coord_en = 1'b1;
        tick();
        Coord_en = 1'b0;
    endtask

    task automatic release_touch();
        Touch_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic press(input logic [2:0] r, input int n);
        Touch_en = 1'b1;
        repeat (n) sample(r);
        repeat (4) tick();
        release_touch();
    endtask

    task automatic lookup(input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp);
        Pixel_X = x;
        Pixel_Y = y;
        exp_pix_q.push_back(exp);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int k;
        k = 0;
        while (State !== s && k < 10) begin
            tick();
            k++;
        end
        check(name, {30'b0, State}, {30'b0, s});
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 3'(i);

        // Reset state
        repeat (3) tick();
        check("reset_rgb", {8'b0, Red, Green, Blue}, 32'h0);
        check("reset_region", {29'b0, Region}, 32'h0);
        check("reset_state", {30'b0, State}, 32'h0);
        check("reset_commit", {31'b0, Commit}, 32'h0);
        Resetn = 1'b1;
        tick();
        lookup(10'd100, 10'd100, 24'h000000);
        lookup(10'd700, 10'd300, 24'hFFFFFF);

        // Four samples in region 1: entry 1 becomes 2 (Blue only)
        expect_commit(3'd1);
        press(3'd1, 4);
        check("region_after_r1", {29'b0, Region}, 32'd1);
        lookup(10'd250, 10'd10, 24'h0000FF);

        // Candidate moves 2 -> 5; only region 5 commits
        expect_commit(3'd5);
        Touch_en = 1'b1;
        sample(3'd2); sample(3'd2);
        sample(3'd5); sample(3'd5); sample(3'd5); sample(3'd5);
        repeat (4) tick();
        release_touch();
        check("region_after_r5", {29'b0, Region}, 32'd5);
        lookup(10'd450, 10'd10, 24'h0000FF);
        lookup(10'd250, 10'd300, 24'h00FFFF);
        lookup(10'd199, 10'd239, 24'h000000);
        lookup(10'd200, 10'd240, 24'h00FFFF);

        // Ten presses on region 7 with one aborted press mixed in
        for (int k = 0; k < 10; k++) begin
            if (k == 2) begin
                Touch_en = 1'b1;
                sample(3'd7); sample(3'd7);
                set_coord(3'd7);
                Coord_en = 1'b1;
                Touch_en = 1'b0;
                tick();
                Coord_en = 1'b0;
                check("drop_with_sample_idle", {30'b0, State}, 32'd0);
                repeat (6) tick();
            end
            expect_commit(3'd7);
            press(3'd7, 4);
            lookup(10'd700, 10'd300, rgb_of(model[7]));
        end
        lookup(10'd700, 10'd300, 24'hFF0000);
        lookup(10'd1000, 10'd300, 24'hFF0000);

        // Lookup during the COMMIT cycle sees the old entry, next lookup the new one
        expect_commit(3'd0);
        Touch_en = 1'b1;
        sample(3'd0); sample(3'd0); sample(3'd0); sample(3'd0);
        wait_state(2'd2, "enter_commit");
        lookup(10'd10, 10'd10, 24'h000000);
        lookup(10'd10, 10'd10, 24'hFF0000);
        release_touch();

        // Reset during SETTLE restores everything
        Touch_en = 1'b1;
        sample(3'd4); sample(3'd4);
        check("in_settle", {30'b0, State}, 32'd1);
        Resetn = 1'b0;
        #1;
        check("async_reset_state", {30'b0, State}, 32'd0);
        tick();
        Resetn = 1'b1;
        Touch_en = 1'b0;
        tick();
        check("reset_mid_region", {29'b0, Region}, 32'd0);
        for (int i = 0; i < 8; i++) model[i] = 3'(i);
        lookup(10'd700, 10'd300, 24'hFFFFFF);
        lookup(10'd250, 10'd10, 24'hFF0000);
        lookup(10'd10, 10'd10, 24'h000000);
        lookup(10'd250, 10'd300, 24'hFFFF00);

        // Hold in region 3 across six frames
        expect_commit(3'd3);
`ifdef TOUCH_REGION_AUTOREPEAT_EN
        expect_commit(3'd3);
        expect_commit(3'd3);
        expect_commit(3'd3);
`endif
        Touch_en = 1'b1;
        sample(3'd3); sample(3'd3); sample(3'd3); sample(3'd3);
        repeat (4) tick();
        for (int f = 0; f < 6; f++) begin
            Frame_start = 1'b1;
            tick();
            Frame_start = 1'b0;
            if (f == 1) sample(3'd3);
            repeat (4) tick();
        end
        release_touch();
        lookup(10'd700, 10'd10, rgb_of(model[3]));

        repeat (4) tick();
        check("commit_count", n_commits, exp_commits);
        check("commit_queue_empty", exp_region_q.size(), 32'd0);
        check("pixel_queue_empty", exp_pix_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/touch_region_sequencer.md
# touch_region_sequencer

Controller between the touch panel controller and the LCD data controller that owns the eight-region colour table: 2 rows × 4 columns of an 800×480 panel. It qualifies pen-down coordinate samples with a settle count and commits exactly one colour step per qualified touch. It also serves a registered per-pixel colour lookup to the LCD data path. This replaces free-running per-cycle colour updates with a sequenced touch → commit → release handshake.

## Interface
Parameters:
- HOLD_SAMPLES, 4: consecutive same-region coordinate samples required before commit (≥1)
- REPEAT_FRAMES, 30: frames between repeats while held (used only with the Configuration macro; ≥1)

Ports:
- Clock  in  1  system clock (50 MHz)
- Resetn  in  1  reset, asynchronous, active-low
- Touch_en  in  1  pen-down level from touch panel controller
- Coord_en  in  1  single-cycle pulse; X_coord/Y_coord valid
- X_coord  in  12  touch X sample
- Y_coord  in  12  touch Y sample
- Frame_start  in  1  single-cycle pulse once per LCD frame
- Pixel_X  in  10  current LCD pixel column, 0–799
- Pixel_Y  in  10  current LCD pixel row, 0–479
- Red  out  8  registered pixel colour
- Green  out  8  registered pixel colour
- Blue  out  8  registered pixel colour
- Region  out  3  last committed region index
- Commit  out  1  single-cycle pulse on each colour step
- State  out  2  FSM state encoding, for debug/LEDs

## Operation
- Touch region index = {Y_coord[11], X_coord[11:10]}.
- Colour table: eight 3-bit entries. Reset value of entry i is i. Bit0 drives Red, bit1 drives Blue, bit2 drives Green; each bit is replicated to 8 bits.
- Commit increments the entry by 1 modulo 8 (7 wraps to 0), drives Region to the committed index, and pulses Commit.
- FSM states and encodings:
  - IDLE (0): on Coord_en & Touch_en, latch the region into cand, set cnt=1, go to SETTLE. If HOLD_SAMPLES=1, go directly to COMMIT.
  - SETTLE (1): Touch_en low → IDLE.
    - Coord_en with the same region: cnt+1. When cnt reaches HOLD_SAMPLES → COMMIT.
    - Coord_en with a different region: cand=new region, cnt=1.
  - COMMIT (2): one cycle. Update the table, pulse Commit, go to HELD.
  - HELD (3): Touch_en low → IDLE. Coord_en samples are ignored, so there are no further commits until release.
- Simultaneous events:
  - Touch_en low in the same cycle as Coord_en: release wins and the sample is discarded.
  - COMMIT always completes, even if Touch_en drops during it.
- Pixel lookup:
  - Row bit = (Pixel_Y ≥ 240).
  - Column = 0 for X 0–199, 1 for 200–399, 2 for 400–599, 3 for 600–799.
  - Pixel region = {row, column}.
  - Pixel_X > 799 maps to column 3.
- cnt width is $clog2(HOLD_SAMPLES+1). cnt saturates and never wraps.
- Reset values: Red/Green/Blue = 0, Region = 0, Commit = 0, State = IDLE, cnt = 0, table = {7,6,5,4,3,2,1,0}.
- Reset asserted mid-operation aborts immediately: no partial commit, and the table returns to its reset values.

## Timing
- Pixel colour latency: 1 cycle. Red/Green/Blue at cycle n+1 reflect Pixel_X/Y and the table contents at cycle n.
- Read-before-write: if a pixel lookup hits the entry being committed, the output shows the old value that cycle and the new value from the next lookup onward.
- Commit pulses in the cycle after the FSM enters COMMIT; Region updates on the same edge.
- Minimum touch → Commit time: HOLD_SAMPLES Coord_en pulses + 1 cycle.
- At most one commit per press (without the Configuration macro). A new press needs Touch_en low for ≥1 cycle.

## Configuration
- TOUCH_REGION_AUTOREPEAT_EN defined:
  - In HELD, a frame counter (width $clog2(REPEAT_FRAMES+1)) counts Frame_start pulses.
  - On reaching REPEAT_FRAMES, if the most recent sample's region equals Region, go to COMMIT and clear the counter.
  - A Coord_en sample in a different region goes to SETTLE with cnt=1 and clears the counter.
  - The counter clears on entry to HELD.
- Undefined: HELD ignores Frame_start and coordinates; no frame counter is synthesized.

## Test plan
- Reset → Red/Green/Blue=0, Region=0, State=0; pixel (100,100) next cycle → colour 0; pixel (700,300) → entry 7 → Red=Green=Blue=8'hFF.
- Touch_en=1, 4 Coord_en samples with X=12'h400, Y=12'h000 → single Commit pulse, Region=1, entry 1 becomes 2 → pixel (250,10) gives Red=0, Blue=8'hFF, Green=0.
- Samples in regions 2,2,5,5,5,5 → exactly one commit, Region=5; no change to entry 2.
- Ten commits on region 7 via separate presses → entry sequence wraps 7→0→…→1; Touch_en dropped alongside the 3rd Coord_en → no commit for that press.
- Commit cycle coincident with a pixel lookup of the same region → old colour shown for that lookup, new colour on the following one; Resetn pulsed while in SETTLE → State=0 and table restored.
- With TOUCH_REGION_AUTOREPEAT_EN, REPEAT_FRAMES=2: hold in region 3 for 6 Frame_start pulses → 4 commits total (initial commit + 3 repeats); without the macro → 1.
